// File: rtl/uart_frame_tx.sv
// Labelled multi-channel frame transmitter over an 8N1 UART line.
// Optional checksum byte before the terminating newline: define UART_FRAME_CKSUM_EN.
module uart_frame_tx #(
    parameter int          NUM_CH     = 3,
    parameter int          CH_BYTES   = 6,
    parameter int          BAUD_DIV   = 5208,
    parameter logic [7:0]  LABEL_BASE = 8'h58
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             Start,
    input  logic [NUM_CH*CH_BYTES*8-1:0]     ChData,
    output logic                             Busy,
    output logic                             Done,
    output logic                             Tx
);

    localparam int NBYTES = NUM_CH * CH_BYTES;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BW     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
`ifdef UART_FRAME_CKSUM_EN
    localparam int FRAME_LEN = NUM_CH * (CH_BYTES + 3) + 2;
`else
    localparam int FRAME_LEN = NUM_CH * (CH_BYTES + 3) + 1;
`endif
    localparam logic [4:0] POS_LAST = 5'(CH_BYTES + 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t              state_reg, state_next;
    logic [BW-1:0]       baud_cnt_reg;
    logic [2:0]          bit_cnt_reg;
    logic [7:0]          byte_idx_reg;
    logic [3:0]          ch_cnt_reg;
    logic [4:0]          pos_cnt_reg;
    logic [NBYTES*8-1:0] snap_reg;
`ifdef UART_FRAME_CKSUM_EN
    logic [7:0]          cksum_reg;
`endif

    logic                baud_end, last_byte, accept, in_frame;
    logic [7:0]          cur_byte;
    logic [IW-1:0]       data_idx;
    logic [7:0]          snap_bytes [NBYTES];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_snap_bytes
            assign snap_bytes[gi] = snap_reg[gi*8 +: 8];
        end
    endgenerate

    assign baud_end  = (baud_cnt_reg == BW'(BAUD_DIV - 1));
    assign last_byte = (byte_idx_reg == 8'(FRAME_LEN - 1));
    assign accept    = Start && ((state_reg == IDLE) || (state_reg == DONE));
    assign in_frame  = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = START;
            START:   if (baud_end) state_next = DATA;
            DATA:    if (baud_end && (bit_cnt_reg == 3'd7)) state_next = STOP;
            STOP:    if (baud_end) state_next = last_byte ? DONE : START;
            DONE:    state_next = Start ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = in_frame;
        Done = (state_reg == DONE);
        case (state_reg)
            START:   Tx = 1'b0;
            DATA:    Tx = cur_byte[bit_cnt_reg];
            default: Tx = 1'b1;
        endcase
    end

    // Channel data bytes go out MSB first, so the flat byte index counts down within a channel.
    always_comb begin
        data_idx = IW'(ch_cnt_reg) * IW'(CH_BYTES) + IW'(CH_BYTES + 1) - IW'(pos_cnt_reg);
        cur_byte = 8'h0A;
        if (ch_cnt_reg < 4'(NUM_CH)) begin
            if (pos_cnt_reg == 5'd0) begin
                cur_byte = LABEL_BASE + 8'(ch_cnt_reg);
            end else if (pos_cnt_reg == 5'd1) begin
                cur_byte = 8'h3A;
            end else if (pos_cnt_reg < POS_LAST) begin
                cur_byte = snap_bytes[data_idx];
            end
        end
`ifdef UART_FRAME_CKSUM_EN
        else if (pos_cnt_reg == 5'd0) begin
            cur_byte = cksum_reg;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            ch_cnt_reg   <= '0;
            pos_cnt_reg  <= '0;
            snap_reg     <= '0;
`ifdef UART_FRAME_CKSUM_EN
            cksum_reg    <= '0;
`endif
        end else if (accept) begin
            snap_reg     <= ChData;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            ch_cnt_reg   <= '0;
            pos_cnt_reg  <= '0;
`ifdef UART_FRAME_CKSUM_EN
            cksum_reg    <= '0;
`endif
        end else if (in_frame) begin
            baud_cnt_reg <= baud_end ? '0 : baud_cnt_reg + BW'(1);
            if (state_reg == START) begin
                bit_cnt_reg <= '0;
            end else if ((state_reg == DATA) && baud_end) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if ((state_reg == STOP) && baud_end) begin
                byte_idx_reg <= byte_idx_reg + 8'd1;
`ifdef UART_FRAME_CKSUM_EN
                cksum_reg    <= cksum_reg ^ cur_byte;
`endif
                if ((ch_cnt_reg < 4'(NUM_CH)) && (pos_cnt_reg == POS_LAST)) begin
                    pos_cnt_reg <= '0;
                    ch_cnt_reg  <= ch_cnt_reg + 4'd1;
                end else begin
                    pos_cnt_reg <= pos_cnt_reg + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: stimulus queues expected bytes, a UART receiver pops and checks.
module tb_uart_frame_tx;

    localparam int NUM_CH   = 2;
    localparam int CH_BYTES = 2;
    localparam int BAUD_DIV = 4;
    localparam int DW       = NUM_CH * CH_BYTES * 8;
`ifdef UART_FRAME_CKSUM_EN
    localparam int FLEN = NUM_CH * (CH_BYTES + 3) + 2;
`else
    localparam int FLEN = NUM_CH * (CH_BYTES + 3) + 1;
`endif
    localparam int BUSY_LEN = FLEN * 10 * BAUD_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] ch_data = '0;
    logic          busy, done, tx;

    always #5 clk = ~clk;

    uart_frame_tx #(
        .NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .BAUD_DIV(BAUD_DIV), .LABEL_BASE(8'h58)
    ) dut (
        .Clk(clk), .Rst(rst), .Start(start), .ChData(ch_data),
        .Busy(busy), .Done(done), .Tx(tx)
    );

    int         checks = 0;
    int         fails = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed frame for ChData = 32'hA53C0FF0 (checksum 8'h67).
    task automatic push_hand();
        logic [7:0] v [10];
        v = '{8'h58, 8'h3A, 8'h0F, 8'hF0, 8'h0A, 8'h59, 8'h3A, 8'hA5, 8'h3C, 8'h0A};
        for (int i = 0; i < 10; i++) exp_q.push_back(v[i]);
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(8'h67);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_frame(input logic [DW-1:0] d);
        logic [7:0] x, b;
        x = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            b = 8'h58 + 8'(c); exp_q.push_back(b); x ^= b;
            b = 8'h3A;         exp_q.push_back(b); x ^= b;
            for (int k = 0; k < CH_BYTES; k++) begin
                b = d[(c*CH_BYTES + CH_BYTES - 1 - k)*8 +: 8];
                exp_q.push_back(b); x ^= b;
            end
            b = 8'h0A;         exp_q.push_back(b); x ^= b;
        end
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(x);
`endif
        exp_q.push_back(8'h0A);
    endtask

    // UART receiver: rx_cnt is the cycle offset from the first start-bit cycle.
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == BAUD_DIV/2) check("start_bit", 32'(tx), 32'd0);
            if (rx_cnt >= BAUD_DIV && rx_cnt < 9*BAUD_DIV && (rx_cnt % BAUD_DIV) == BAUD_DIV/2)
                rx_byte[rx_cnt/BAUD_DIV - 1] <= tx;
            if (rx_cnt == 9*BAUD_DIV + BAUD_DIV/2) begin
                check("stop_bit", 32'(tx), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(rx_byte), 32'h100);
                end else begin
                    check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                end
            end
            if (rx_cnt == 10*BAUD_DIV - 1) rx_act <= 1'b0;
        end
    end

    int busy_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run <= 0;
        end else if (busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            check("busy_len", 32'(busy_run), 32'(BUSY_LEN));
            busy_run <= 0;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            check("done_busy_tx", {30'd0, busy, tx}, 32'b01);
        end
    end

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    int done_before;

    initial begin
        ch_data = 32'hA53C0FF0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Start already high on the first cycle after reset release
        start = 1'b1;
        push_hand();
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("accept_after_rst", {30'd0, busy, tx}, 32'b10);
        wait_done(BUSY_LEN + 20);

        // Snapshot isolation and ignored re-start
        @(negedge clk);
        ch_data = 32'h12345678;
        push_frame(32'h12345678);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_b", {30'd0, busy, tx}, 32'b10);
        repeat (50) @(negedge clk);
        ch_data = '1;
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(BUSY_LEN + 20);
        repeat (60) @(negedge clk);
        check("no_requeued_frame", 32'(busy), 32'd0);
        check("queue_drained_b", 32'(exp_q.size()), 32'd0);

        // Mid-frame abort
        ch_data = 32'hDEADBEEF;
        push_frame(32'hDEADBEEF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (56) @(negedge clk);
        done_before = done_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(done_before));

        ch_data = 32'h00FF8001;
        push_frame(32'h00FF8001);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_after_abort", {30'd0, busy, tx}, 32'b10);
        wait_done(BUSY_LEN + 20);

        // Start held high: back-to-back frames
        @(negedge clk);
        ch_data = 32'hA53C0FF0;
        push_hand();
        push_hand();
        start = 1'b1;
        @(negedge clk);
        wait_done(BUSY_LEN + 20);
        @(negedge clk);
        check("b2b_restart", {30'd0, busy, tx}, 32'b10);
        start = 1'b0;
        wait_done(BUSY_LEN + 20);

        repeat (20) @(negedge clk);
        check("queue_drained_end", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
